// File: rtl/dmem_pkg.sv
// Shared defaults and helpers for the data-memory responder.
// Holds the range check and the saturating counter increment.
package dmem_pkg;

    localparam int DMEM_DATA_WIDTH = 64;
    localparam int DMEM_ADDR_WIDTH = 32;
    localparam int DMEM_DEPTH_LOG2 = 8;
    localparam int DMEM_CNT_WIDTH  = 32;

    // A word address is legal only when every bit above the index field is zero.
    function automatic logic in_range(input logic [63:0] addr, input int depthLog2);
        return (addr >> depthLog2) == 64'd0;
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int width);
        logic [63:0] maxVal;
        maxVal = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (cnt == maxVal) ? cnt : cnt + 64'd1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-read single-write synchronous word array with a registered read port.
// The read register clears on reset and can be zeroed on demand.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents survive reset; only writes sampled while reset is high are blocked.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rclr) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the core's load/store port with a preload port,
// out-of-range detection, sticky error flags and saturating access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2,
    parameter int CNT_WIDTH  = DMEM_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_enable,
    input  logic                  store_enable,
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic [DATA_WIDTH-1:0] dmem_dataIn,
    output logic [DATA_WIDTH-1:0] dmem_dataOut,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_data,
    output logic                  range_err,
    output logic                  init_drop,
    output logic [CNT_WIDTH-1:0]  load_count,
    output logic [CNT_WIDTH-1:0]  store_count
);

    logic                  loadReq;
    logic                  storeReq;
    logic                  inRange;
    logic [DEPTH_LOG2-1:0] index;
    logic                  coreWrite;
    logic                  arrayWe;
    logic [DEPTH_LOG2-1:0] arrayWaddr;
    logic [DATA_WIDTH-1:0] arrayWdata;

    logic                  rangeErr_q, rangeErr_d;
    logic                  initDrop_q, initDrop_d;
    logic [CNT_WIDTH-1:0]  loadCount_q, loadCount_d;
    logic [CNT_WIDTH-1:0]  storeCount_q, storeCount_d;

    assign loadReq  = mem_enable & ~store_enable;
    assign storeReq = mem_enable & store_enable;
    assign inRange  = in_range(64'(dmem_address), DEPTH_LOG2);
    assign index    = dmem_address[DEPTH_LOG2-1:0];

    // Any core store, even a dropped out-of-range one, takes the write port from preload.
    assign coreWrite  = storeReq & inRange;
    assign arrayWe    = coreWrite | (init_we & ~storeReq);
    assign arrayWaddr = coreWrite ? index : init_addr;
    assign arrayWdata = coreWrite ? dmem_dataIn : init_data;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arrayWe),
        .waddr (arrayWaddr),
        .wdata (arrayWdata),
        .re    (loadReq & inRange),
        .rclr  (loadReq & ~inRange),
        .raddr (index),
        .rdata (dmem_dataOut)
    );

    always_comb begin
        rangeErr_d   = rangeErr_q | ((loadReq | storeReq) & ~inRange);
        initDrop_d   = initDrop_q | (init_we & storeReq);
        loadCount_d  = loadCount_q;
        storeCount_d = storeCount_q;
        if (loadReq && inRange) begin
            loadCount_d = CNT_WIDTH'(sat_inc(64'(loadCount_q), CNT_WIDTH));
        end
        if (storeReq && inRange) begin
            storeCount_d = CNT_WIDTH'(sat_inc(64'(storeCount_q), CNT_WIDTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rangeErr_q   <= 1'b0;
            initDrop_q   <= 1'b0;
            loadCount_q  <= '0;
            storeCount_q <= '0;
        end else begin
            rangeErr_q   <= rangeErr_d;
            initDrop_q   <= initDrop_d;
            loadCount_q  <= loadCount_d;
            storeCount_q <= storeCount_d;
        end
    end

    assign range_err   = rangeErr_q;
    assign init_drop   = initDrop_q;
    assign load_count  = loadCount_q;
    assign store_count = storeCount_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by a
// randomized run against a word-array reference model, plus a narrow-counter twin.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        memEnable;
    logic        storeEnable;
    logic [31:0] dmemAddress;
    logic [63:0] dmemDataIn;
    logic [63:0] dmemDataOut;
    logic        initWe;
    logic [7:0]  initAddr;
    logic [63:0] initData;
    logic        rangeErr;
    logic        initDrop;
    logic [31:0] loadCount;
    logic [31:0] storeCount;

    logic [63:0] smallDataOut;
    logic        smallRangeErr;
    logic        smallInitDrop;
    logic [2:0]  smallLoadCount;
    logic [2:0]  smallStoreCount;

    int unsigned vectors;
    int unsigned miscompares;

    logic [63:0] mdlMem [256];
    logic [63:0] expOut;
    logic        expRangeErr;
    logic        expInitDrop;
    longint      expLoads;
    longint      expStores;

    dmem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .mem_enable   (memEnable),
        .store_enable (storeEnable),
        .dmem_address (dmemAddress),
        .dmem_dataIn  (dmemDataIn),
        .dmem_dataOut (dmemDataOut),
        .init_we      (initWe),
        .init_addr    (initAddr),
        .init_data    (initData),
        .range_err    (rangeErr),
        .init_drop    (initDrop),
        .load_count   (loadCount),
        .store_count  (storeCount)
    );

    dmem_responder #(.CNT_WIDTH(3)) dutSmall (
        .clk          (clk),
        .rst          (rst),
        .mem_enable   (memEnable),
        .store_enable (storeEnable),
        .dmem_address (dmemAddress),
        .dmem_dataIn  (dmemDataIn),
        .dmem_dataOut (smallDataOut),
        .init_we      (initWe),
        .init_addr    (initAddr),
        .init_data    (initData),
        .range_err    (smallRangeErr),
        .init_drop    (smallInitDrop),
        .load_count   (smallLoadCount),
        .store_count  (smallStoreCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic longint satAt(input longint count, input longint maxVal);
        return (count > maxVal) ? maxVal : count;
    endfunction

    // Drive one request, let one edge pass, and advance the reference model.
    task automatic applyStimulus(input logic me, input logic se, input logic [31:0] addr,
                                 input logic [63:0] din, input logic iwe,
                                 input logic [7:0] iaddr, input logic [63:0] idata);
        bit isLoad, isStore, legal;
        memEnable   = me;
        storeEnable = se;
        dmemAddress = addr;
        dmemDataIn  = din;
        initWe      = iwe;
        initAddr    = iaddr;
        initData    = idata;
        @(posedge clk);
        isLoad  = me && !se;
        isStore = me && se;
        legal   = addr < 32'd256;
        if (isLoad) begin
            if (legal) begin
                expOut = mdlMem[addr[7:0]];
                expLoads++;
            end else begin
                expOut = 64'd0;
                expRangeErr = 1'b1;
            end
        end
        if (isStore) begin
            if (legal) begin
                mdlMem[addr[7:0]] = din;
                expStores++;
            end else begin
                expRangeErr = 1'b1;
            end
            if (iwe) expInitDrop = 1'b1;
        end else if (iwe) begin
            mdlMem[iaddr] = idata;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".dataOut"}, dmemDataOut, expOut);
        compare({tag, ".rangeErr"}, 64'(rangeErr), 64'(expRangeErr));
        compare({tag, ".initDrop"}, 64'(initDrop), 64'(expInitDrop));
        compare({tag, ".loadCount"}, 64'(loadCount), 64'(satAt(expLoads, 64'hFFFF_FFFF)));
        compare({tag, ".storeCount"}, 64'(storeCount), 64'(satAt(expStores, 64'hFFFF_FFFF)));
        compare({tag, ".smallLoads"}, 64'(smallLoadCount), 64'(satAt(expLoads, 7)));
        compare({tag, ".smallStores"}, 64'(smallStoreCount), 64'(satAt(expStores, 7)));
    endtask

    task automatic modelReset();
        expOut      = 64'd0;
        expRangeErr = 1'b0;
        expInitDrop = 1'b0;
        expLoads    = 0;
        expStores   = 0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 8'd0, 64'd0);
    endtask

    initial begin
        logic [31:0] rAddr;
        vectors     = 0;
        miscompares = 0;
        memEnable   = 1'b0;
        storeEnable = 1'b0;
        dmemAddress = '0;
        dmemDataIn  = '0;
        initWe      = 1'b0;
        initAddr    = '0;
        initData    = '0;
        modelReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset");

        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 8'(i), {$urandom, $urandom});
        end
        checkOutput("preloadAll");

        applyStimulus(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 8'd3, 64'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 32'd3, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("loadPreloaded");
        compare("loadPreloaded.value", dmemDataOut, 64'hDEAD_BEEF);

        applyStimulus(1'b1, 1'b1, 32'd7, 64'h1234, 1'b0, 8'd0, 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd7, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("storeThenLoad");
        compare("storeThenLoad.value", dmemDataOut, 64'h1234);

        applyStimulus(1'b1, 1'b0, 32'd9, 64'd0, 1'b1, 8'd9, 64'hAAAA_5555);
        checkOutput("loadWithPreloadSameIdx");
        applyStimulus(1'b1, 1'b0, 32'd9, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("preloadLanded");
        compare("preloadLanded.value", dmemDataOut, 64'hAAAA_5555);

        applyStimulus(1'b1, 1'b0, 32'h100, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("loadOutOfRange");
        compare("loadOutOfRange.flag", 64'(rangeErr), 64'd1);
        applyStimulus(1'b1, 1'b1, 32'h200, 64'hBAD0, 1'b0, 8'd0, 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("storeOutOfRange");

        applyStimulus(1'b1, 1'b1, 32'd2, 64'h2222, 1'b1, 8'd9, 64'h9999);
        checkOutput("preloadDropped");
        compare("preloadDropped.flag", 64'(initDrop), 64'd1);
        applyStimulus(1'b1, 1'b0, 32'd9, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("mem9Unchanged");
        applyStimulus(1'b1, 1'b0, 32'd2, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("mem2Updated");
        compare("mem2Updated.value", dmemDataOut, 64'h2222);

        applyStimulus(1'b0, 1'b1, 32'd4, 64'hFFFF, 1'b0, 8'd0, 64'd0);
        checkOutput("storeEnableAlone");
        applyStimulus(1'b1, 1'b0, 32'd4, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("storeEnableAloneRead");

        for (int i = 0; i < 600; i++) begin
            rAddr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rAddr,
                          {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
                          8'($urandom_range(0, 255)), {$urandom, $urandom});
            checkOutput("random");
        end

        // Reset mid-run with a store to word 5 and a preload sampled while reset is high.
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("midReset");
        memEnable   = 1'b1;
        storeEnable = 1'b1;
        dmemAddress = 32'd5;
        dmemDataIn  = 64'hBAD_BAD;
        initWe      = 1'b1;
        initAddr    = 8'd6;
        initData    = 64'hBAD_BAD;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        checkOutput("afterReset");
        applyStimulus(1'b1, 1'b0, 32'd5, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("word5Kept");
        applyStimulus(1'b1, 1'b0, 32'd6, 64'd0, 1'b0, 8'd0, 64'd0);
        checkOutput("word6Kept");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
